// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared state encoding and constants for the SDRAM arbiter
package sdram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CMD  = 1'b1
  } arb_state_t;

  localparam logic [3:0] BE_N_LOW16 = 4'b1100;
  localparam int         DATA_W     = 16;

endpackage

// File: rtl/sdram_tag_fifo.sv
// rtl/sdram_tag_fifo.sv - in-order FIFO of channel ids for reads awaiting readdatavalid
module sdram_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin arbiter of N_CH 16-bit clients onto one Avalon SDRAM master
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 23,
  parameter int MAX_RD = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_CH*ADDR_W-1:0]   sdram_addr,
  input  logic [N_CH-1:0]          sdram_read,
  input  logic [N_CH-1:0]          sdram_write,
  input  logic [N_CH*DATA_W-1:0]   sdram_writedata,
  output logic [DATA_W-1:0]        sdram_readdata,
  output logic [N_CH-1:0]          sdram_finished,
  output logic [ADDR_W-1:0]        new_sdram_controller_0_s1_address,
  output logic [3:0]               new_sdram_controller_0_s1_byteenable_n,
  output logic                     new_sdram_controller_0_s1_chipselect,
  output logic [31:0]              new_sdram_controller_0_s1_writedata,
  output logic                     new_sdram_controller_0_s1_read_n,
  output logic                     new_sdram_controller_0_s1_write_n,
  input  logic [31:0]              new_sdram_controller_0_s1_readdata,
  input  logic                     new_sdram_controller_0_s1_readdatavalid,
  input  logic                     new_sdram_controller_0_s1_waitrequest
);

  localparam int ID_W = $clog2(N_CH);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   lat_id;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [N_CH-1:0]   in_flight;
  logic [N_CH-1:0]   eligible;
  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic              accept;
  logic              in_cmd;
  logic              pop;
  logic [ID_W-1:0]   pop_id;
  logic              fifo_full;
  logic              fifo_empty;
  logic              unused_rdata_hi;

  function automatic logic [N_CH-1:0] onehot(input logic [ID_W-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  // Writes bypass the tag FIFO, so only reads are held back when it is full.
  assign eligible = ~in_flight & (sdram_write | (sdram_read & {N_CH{~fifo_full}}));

  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(last_grant) + i) % N_CH;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (grant_found) state_next = CMD;
      CMD: begin
        if (!i_rst && !new_sdram_controller_0_s1_waitrequest) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(N_CH - 1);
      lat_id     <= '0;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      in_flight  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_found) begin
        lat_id   <= grant_id;
        lat_wr   <= sdram_write[grant_id];
        lat_addr <= sdram_addr[grant_id*ADDR_W +: ADDR_W];
        lat_data <= sdram_writedata[grant_id*DATA_W +: DATA_W];
      end
      if (accept) last_grant <= lat_id;
      in_flight <= (in_flight | ((accept && !lat_wr) ? onehot(lat_id) : '0))
                 & ~(pop ? onehot(pop_id) : '0);
    end
  end

  sdram_tag_fifo #(
    .DEPTH (MAX_RD),
    .WIDTH (ID_W)
  ) u_tag_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (accept && !lat_wr),
    .push_data (lat_id),
    .pop       (pop),
    .pop_data  (pop_id),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Outputs are gated by reset so the bus is quiet even in the first reset cycle.
  assign in_cmd = (state == CMD) && !i_rst;
  assign pop    = new_sdram_controller_0_s1_readdatavalid && !fifo_empty && !i_rst;

  assign new_sdram_controller_0_s1_read_n       = !(in_cmd && !lat_wr);
  assign new_sdram_controller_0_s1_write_n      = !(in_cmd && lat_wr);
  assign new_sdram_controller_0_s1_address      = in_cmd ? lat_addr : '0;
  assign new_sdram_controller_0_s1_writedata    = in_cmd ? {{(32-DATA_W){1'b0}}, lat_data} : 32'h0;
  assign new_sdram_controller_0_s1_byteenable_n = BE_N_LOW16;
  assign new_sdram_controller_0_s1_chipselect   = 1'b1;

  assign sdram_readdata  = pop ? new_sdram_controller_0_s1_readdata[DATA_W-1:0] : '0;
  assign sdram_finished  = ((accept && lat_wr) ? onehot(lat_id) : '0) | (pop ? onehot(pop_id) : '0);
  assign unused_rdata_hi = ^new_sdram_controller_0_s1_readdata[31:DATA_W];

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter
module tb_sdram_arbiter;

  localparam int N_CH   = 6;
  localparam int ADDR_W = 23;
  localparam int MAX_RD = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_CH*ADDR_W-1:0] sdram_addr;
  logic [N_CH-1:0]        sdram_read;
  logic [N_CH-1:0]        sdram_write;
  logic [N_CH*16-1:0]     sdram_writedata;
  logic [15:0]            sdram_readdata;
  logic [N_CH-1:0]        sdram_finished;
  logic [ADDR_W-1:0]      av_address;
  logic [3:0]             av_be_n;
  logic                   av_cs;
  logic [31:0]            av_wdata;
  logic                   av_read_n;
  logic                   av_write_n;
  logic [31:0]            av_rdata;
  logic                   av_rdv;
  logic                   av_wait;

  // Request level = toggle from stimulus xor ack from monitor.
  logic [N_CH-1:0] rd_tog, rd_ack, wr_tog, wr_ack;
  assign sdram_read  = rd_tog ^ rd_ack;
  assign sdram_write = wr_tog ^ wr_ack;

  always #5 clk = ~clk;

  sdram_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .MAX_RD(MAX_RD)) dut (
    .i_clk                                   (clk),
    .i_rst                                   (rst),
    .sdram_addr                              (sdram_addr),
    .sdram_read                              (sdram_read),
    .sdram_write                             (sdram_write),
    .sdram_writedata                         (sdram_writedata),
    .sdram_readdata                          (sdram_readdata),
    .sdram_finished                          (sdram_finished),
    .new_sdram_controller_0_s1_address       (av_address),
    .new_sdram_controller_0_s1_byteenable_n  (av_be_n),
    .new_sdram_controller_0_s1_chipselect    (av_cs),
    .new_sdram_controller_0_s1_writedata     (av_wdata),
    .new_sdram_controller_0_s1_read_n        (av_read_n),
    .new_sdram_controller_0_s1_write_n       (av_write_n),
    .new_sdram_controller_0_s1_readdata      (av_rdata),
    .new_sdram_controller_0_s1_readdatavalid (av_rdv),
    .new_sdram_controller_0_s1_waitrequest   (av_wait)
  );

  typedef struct {
    int                ch;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } cmd_t;

  typedef struct {
    int                ch;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    int                wt;
    logic [15:0]       rdata;
  } vec_t;

  cmd_t              exp_cmd[$];
  int                model_tags[$];
  int                compared   = 0;
  int                mismatched = 0;
  int                cmd_len    = 0;
  int                last_len   = 0;
  logic [ADDR_W-1:0] first_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [15:0] d);
    sdram_addr[ch*ADDR_W +: ADDR_W] = a;
    sdram_writedata[ch*16 +: 16]    = d;
    rd_tog[ch] = rd_ack[ch] ^ rd;
    wr_tog[ch] = wr_ack[ch] ^ wr;
  endtask

  task automatic expect_cmd(input int ch, input logic wr, input logic [ADDR_W-1:0] a,
                            input logic [15:0] d);
    exp_cmd.push_back(cmd_t'{ch, wr, a, d});
  endtask

  function automatic logic [ADDR_W-1:0] ch_addr(input int ch);
    return ADDR_W'(32'h1000 + ch * 16);
  endfunction

  task automatic wait_cmds(input string name, input int budget);
    int n = 0;
    while (exp_cmd.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_cmds_pending"}, 64'(exp_cmd.size()), 0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((sdram_read | sdram_write) != '0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_reqs_pending"}, 64'(sdram_read | sdram_write), 0);
  endtask

  task automatic return_read(input logic [15:0] d);
    av_rdv   = 1'b1;
    av_rdata = {16'hDEAD, d};
    tick();
    av_rdv   = 1'b0;
    av_rdata = 32'h0;
  endtask

  // Monitor: scoreboard for bus commands, in-order read returns and done pulses.
  initial begin
    cmd_t            e;
    int              ch;
    logic [N_CH-1:0] fin_mask;
    forever begin
      @(negedge clk);
      fin_mask = '0;
      if (rst) begin
        model_tags.delete();
        cmd_len = 0;
        check("rst_read_n", 64'(av_read_n), 1);
        check("rst_write_n", 64'(av_write_n), 1);
        check("rst_finished", 64'(sdram_finished), 0);
        check("rst_readdata", 64'(sdram_readdata), 0);
        check("rst_address", 64'(av_address), 0);
        check("rst_writedata", 64'(av_wdata), 0);
      end else begin
        if (!av_read_n || !av_write_n) begin
          check("cmd_exclusive", 64'(av_read_n ^ av_write_n), 1);
          if (cmd_len == 0) first_addr = av_address;
          cmd_len++;
          check("addr_stable", 64'(av_address), 64'(first_addr));
          if (!av_wait) begin
            last_len = cmd_len;
            cmd_len  = 0;
            if (exp_cmd.size() == 0) begin
              compared++;
              mismatched++;
              $display("FAIL unexpected_cmd: got command at address %0h, expected none", av_address);
            end else begin
              e = exp_cmd.pop_front();
              check("cmd_write_n", 64'(av_write_n), 64'(!e.wr));
              check("cmd_addr", 64'(av_address), 64'(e.addr));
              check("cmd_be_n", 64'(av_be_n), 64'(4'b1100));
              if (e.wr) begin
                check("cmd_wdata", 64'(av_wdata), 64'({16'h0, e.data}));
                fin_mask[e.ch] = 1'b1;
                wr_ack[e.ch]   = wr_tog[e.ch];
                rd_ack[e.ch]   = rd_tog[e.ch];
              end else begin
                model_tags.push_back(e.ch);
              end
            end
          end
        end
        if (av_rdv && model_tags.size() > 0) begin
          ch = model_tags.pop_front();
          fin_mask[ch] = 1'b1;
          check("read_data", 64'(sdram_readdata), 64'(av_rdata[15:0]));
          rd_ack[ch] = rd_tog[ch];
        end
        if (fin_mask != '0 || sdram_finished != '0)
          check("finished", 64'(sdram_finished), 64'(fin_mask));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[5];

  initial begin
    vecs[0] = '{2, 1'b0, 1'b1, 23'h000100, 16'hBEEF, 0, 16'h0000};
    vecs[1] = '{1, 1'b1, 1'b0, 23'h000200, 16'h0000, 5, 16'h1234};
    vecs[2] = '{5, 1'b0, 1'b1, 23'h7FFFFF, 16'hFFFF, 2, 16'h0000};
    vecs[3] = '{0, 1'b1, 1'b0, 23'h000000, 16'h0000, 0, 16'hA5A5};
    vecs[4] = '{3, 1'b1, 1'b1, 23'h012345, 16'h5555, 1, 16'h0000};

    rst = 1'b1;
    rd_tog = '0; rd_ack = '0; wr_tog = '0; wr_ack = '0;
    sdram_addr = '0; sdram_writedata = '0;
    av_rdata = 32'h0; av_rdv = 1'b0; av_wait = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("chipselect", 64'(av_cs), 1);
    check("idle_read_n", 64'(av_read_n), 1);

    // Single transactions: writes, stalled reads, write-over-read priority.
    foreach (vecs[i]) begin
      av_wait = (vecs[i].wt > 0);
      expect_cmd(vecs[i].ch, vecs[i].wr, vecs[i].addr, vecs[i].data);
      set_req(vecs[i].ch, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data);
      if (vecs[i].wt > 0) begin
        repeat (vecs[i].wt + 1) tick();
        av_wait = 1'b0;
      end
      wait_cmds("vec", 30);
      check("vec_cmd_len", 64'(last_len), 64'(vecs[i].wt + 1));
      if (!vecs[i].wr) return_read(vecs[i].rdata);
      wait_idle("vec", 30);
      tick();
    end

    // Request withdrawn during a stalled command still completes.
    av_wait = 1'b1;
    expect_cmd(4, 1'b1, 23'h00ABCD, 16'h4444);
    set_req(4, 1'b0, 1'b1, 23'h00ABCD, 16'h4444);
    tick();
    tick();
    set_req(4, 1'b0, 1'b0, 23'h00ABCD, 16'h4444);
    tick();
    tick();
    av_wait = 1'b0;
    wait_cmds("drop", 20);
    check("drop_cmd_len", 64'(last_len), 4);
    repeat (4) tick();

    // Round robin across ch0..3, then ch0 again after it completes.
    for (int c = 0; c < 4; c++) expect_cmd(c, 1'b0, ch_addr(c), 16'h0);
    for (int c = 0; c < 4; c++) set_req(c, 1'b1, 1'b0, ch_addr(c), 16'h0);
    wait_cmds("rr", 40);
    return_read(16'h0A0A);
    check("rr_ch0_released", 64'(sdram_read[0]), 0);
    expect_cmd(0, 1'b0, ch_addr(0), 16'h0);
    set_req(0, 1'b1, 1'b0, ch_addr(0), 16'h0);
    wait_cmds("rr_again", 20);
    for (int k = 0; k < 4; k++) return_read(16'h0B00 + 16'(k));
    wait_idle("rr", 20);
    tick();

    // Outstanding limit: six reads, only four tags until a return frees one.
    for (int c = 1; c <= 4; c++) expect_cmd(c, 1'b0, ch_addr(c), 16'h0);
    for (int c = 0; c < N_CH; c++) set_req(c, 1'b1, 1'b0, ch_addr(c), 16'h0);
    wait_cmds("limit", 40);
    repeat (8) tick();
    check("limit_stalled_read_n", 64'(av_read_n), 1);
    expect_cmd(5, 1'b0, ch_addr(5), 16'h0);
    return_read(16'hC001);
    wait_cmds("limit_fifth", 20);
    expect_cmd(0, 1'b0, ch_addr(0), 16'h0);
    return_read(16'hC002);
    wait_cmds("limit_sixth", 20);
    for (int k = 0; k < 4; k++) return_read(16'hC010 + 16'(k));
    wait_idle("limit", 20);
    tick();

    // In-order return: ch3 then ch0 issued, data delivered in issue order.
    expect_cmd(3, 1'b0, ch_addr(3), 16'h0);
    expect_cmd(0, 1'b0, ch_addr(0), 16'h0);
    set_req(3, 1'b1, 1'b0, ch_addr(3), 16'h0);
    set_req(0, 1'b1, 1'b0, ch_addr(0), 16'h0);
    wait_cmds("order", 20);
    return_read(16'h1111);
    check("order_ch0_still_waiting", 64'(sdram_read[0]), 1);
    return_read(16'h2222);
    wait_idle("order", 10);
    tick();

    // Reset with two tags pending: later returns are discarded.
    expect_cmd(1, 1'b0, ch_addr(1), 16'h0);
    expect_cmd(2, 1'b0, ch_addr(2), 16'h0);
    set_req(1, 1'b1, 1'b0, ch_addr(1), 16'h0);
    set_req(2, 1'b1, 1'b0, ch_addr(2), 16'h0);
    wait_cmds("rstmid", 20);
    rst = 1'b1;
    set_req(1, 1'b0, 1'b0, ch_addr(1), 16'h0);
    set_req(2, 1'b0, 1'b0, ch_addr(2), 16'h0);
    tick();
    tick();
    rst = 1'b0;
    av_rdv   = 1'b1;
    av_rdata = 32'h0000_7777;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_finished", 64'(sdram_finished), 0);
      check("post_rst_readdata", 64'(sdram_readdata), 0);
      @(posedge clk);
      #1;
    end
    av_rdv   = 1'b0;
    av_rdata = 32'h0;
    check("post_rst_read_n", 64'(av_read_n), 1);
    check("post_rst_write_n", 64'(av_write_n), 1);
    expect_cmd(5, 1'b1, 23'h000055, 16'h9999);
    set_req(5, 1'b0, 1'b1, 23'h000055, 16'h9999);
    wait_cmds("post_rst", 20);
    check("post_rst_cmd_len", 64'(last_len), 1);
    wait_idle("post_rst", 10);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of client channels (2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 23, giving the SDRAM word address width.
REQ-003 The block SHALL have parameter MAX_RD, default 4, giving the maximum number of outstanding reads (power of two, 2..16).
REQ-004 The block SHALL have port i_clk, input, width 1: the single clock.
REQ-005 The block SHALL have port i_rst, input, width 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port sdram_addr, input, width N_CH*ADDR_W: per-channel address, channel k at slice k.
REQ-007 The block SHALL have port sdram_read, input, width N_CH: per-channel read request, level.
REQ-008 The block SHALL have port sdram_write, input, width N_CH: per-channel write request, level.
REQ-009 The block SHALL have port sdram_writedata, input, width N_CH*16: per-channel write data.
REQ-010 The block SHALL have port sdram_readdata, output, width 16: shared read data, valid only with a read-done pulse.
REQ-011 The block SHALL have port sdram_finished, output, width N_CH: per-channel one-cycle done pulse.
REQ-012 The block SHALL have Avalon master ports new_sdram_controller_0_s1_{address[ADDR_W], byteenable_n[4], chipselect, writedata[32], read_n, write_n} as outputs and {readdata[32], readdatavalid, waitrequest} as inputs.

Function
REQ-013 A client SHALL hold read or write until its sdram_finished pulse; if both are high on one channel, write SHALL win.
REQ-014 A channel SHALL be eligible when it requests and has no transaction in flight (in-flight flag clear).
REQ-015 Arbitration SHALL be round-robin: the search starts at last_grant+1 mod N_CH; last_grant resets to N_CH-1.
REQ-016 The FSM SHALL have states IDLE and CMD.
REQ-017 In IDLE with any eligible channel, the FSM SHALL latch the winner's id, op, address, and data, then enter CMD next cycle.
REQ-018 A read SHALL be ineligible while the tag FIFO is full; writes SHALL remain eligible.
REQ-019 In CMD, read_n or write_n SHALL be driven low from the latched op.
REQ-020 In CMD, writedata SHALL be {16'h0, data} and byteenable_n SHALL be 4'b1100.
REQ-021 chipselect SHALL be constant 1.
REQ-022 In CMD with waitrequest low, the command SHALL be accepted: FSM goes to IDLE and last_grant becomes the latched id.
REQ-023 On write acceptance, sdram_finished[id] SHALL pulse in that same cycle.
REQ-024 On read acceptance, the id SHALL be pushed to the tag FIFO and in-flight[id] SHALL be set.
REQ-025 On readdatavalid with the FIFO non-empty, the block SHALL pop the id, pulse sdram_finished[id], and drive sdram_readdata = readdata[15:0] in that cycle.
REQ-026 That same readdatavalid event SHALL clear in-flight[id].
REQ-027 readdatavalid with the FIFO empty SHALL be discarded, with no pulse.
REQ-028 A simultaneous push and pop SHALL both take effect, and the count SHALL be unchanged.
REQ-029 Minimum latency request to command on the bus SHALL be 1 cycle.
REQ-030 At most one command SHALL be on the bus at a time.
REQ-031 FIFO pointers SHALL wrap modulo MAX_RD.
REQ-032 A dropped request while in CMD SHALL NOT abort the latched command.

Reset
REQ-033 On i_rst, the FSM SHALL return to IDLE.
REQ-034 On i_rst, the FIFO SHALL be empty and all in-flight flags cleared.
REQ-035 On i_rst, last_grant SHALL be N_CH-1.
REQ-036 During and after reset, read_n and write_n SHALL be 1 and sdram_finished SHALL be 0.
REQ-037 During and after reset, sdram_readdata and the Avalon address and writedata SHALL be 0.
REQ-038 Reset mid-read SHALL drop pending tags; later readdatavalid SHALL be discarded per REQ-027.

Structure
REQ-039 Package sdram_arb_pkg SHALL hold the FSM state enum, the BE_N_LOW16 = 4'b1100 constant, and the 16-bit client data width.
REQ-040 Tag FIFO SHALL be sub-module sdram_tag_fifo (depth MAX_RD, width clog2(N_CH)), with full and empty flags.

Verification
REQ-041 Single write: ch2 write addr 0x000100 data 0xBEEF, waitrequest low -> write_n low 1 cycle, writedata 0x0000BEEF, finished[2] pulses.
REQ-042 Round-robin: ch0..3 all request reads at once, waitrequest 0 -> issue order 0,1,2,3, then 0 again after ch0 completes.
REQ-043 Waitrequest stall: ch1 read, waitrequest high 5 cycles -> read_n held low 6 cycles, address stable, one tag pushed.
REQ-044 Outstanding limit: MAX_RD=4, readdatavalid withheld, 6 reads from 6 channels (N_CH=6) -> 4 issued, 5th stalls until the first readdatavalid.
REQ-045 Out-of-order return not allowed: returns 0x1111, 0x2222 for ch3, ch0 issues -> finished[3] with 0x1111, then finished[0] with 0x2222.
REQ-046 Reset mid-read: 2 tags pending, pulse i_rst, then readdatavalid twice -> no finished pulses, FSM in IDLE.
